// File: rtl/egr_pfs_fetch_sched.sv
// egr_pfs_fetch_sched: round-robin fetch issue slot shared by N_REQ egress requesters,
// with per-requester outstanding-credit limits and DPB stall gating of new grants.
module egr_pfs_fetch_sched #(
    parameter int N_REQ     = 4,
    parameter int PTR_W     = 20,
    parameter int MAX_OUTST = 8,
    localparam int IDX_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dpb_stall,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*PTR_W-1:0] req_ptr,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [IDX_W-1:0]       fetch_port,
    output logic [PTR_W-1:0]       fetch_ptr,
    input  logic                   cmpl_valid,
    input  logic [IDX_W-1:0]       cmpl_port,
    output logic [N_REQ*CNT_W-1:0] outst_cnt,
    output logic [15:0]            stall_cnt,
    output logic                   cmpl_err
);
    logic [CNT_W-1:0] r_cnt [N_REQ];
    logic [IDX_W-1:0] r_rr;
    logic             r_fv;
    logic [IDX_W-1:0] r_port;
    logic [PTR_W-1:0] r_ptr;
    logic [15:0]      r_stall;
    logic             r_err;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_hit;
    logic [N_REQ-1:0] w_nz;
    logic [N_REQ-1:0] w_inc;
    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic             w_grant;
    logic             w_cmpl_bad;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign w_elig[g] = req_valid[g] && (r_cnt[g] < CNT_W'(MAX_OUTST)) && !dpb_stall;
        assign w_hit[g]  = cmpl_valid && (cmpl_port == IDX_W'(g));
        assign w_nz[g]   = r_cnt[g] != '0;
        assign w_inc[g]  = w_grant && (w_win == IDX_W'(g));
        assign outst_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(r_rr) + k) % N_REQ;
            if (w_elig[j] && !w_any) begin
                w_any = 1'b1;
                w_win = IDX_W'(j);
            end
        end
    end

    // Reset also forces req_ready low so no handshake is seen while in reset.
    assign w_grant     = rst_n && (!r_fv || fetch_ready) && w_any;
    assign req_ready   = w_grant ? (N_REQ'(1) << w_win) : '0;
    assign w_cmpl_bad  = cmpl_valid && !(|(w_hit & w_nz));
    assign fetch_valid = r_fv;
    assign fetch_port  = r_port;
    assign fetch_ptr   = r_ptr;
    assign stall_cnt   = r_stall;
    assign cmpl_err    = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= '0;
            r_fv    <= 1'b0;
            r_port  <= '0;
            r_ptr   <= '0;
            r_stall <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else begin
            if (w_grant) begin
                r_fv   <= 1'b1;
                r_port <= w_win;
                r_ptr  <= req_ptr[w_win*PTR_W +: PTR_W];
                r_rr   <= (w_win == IDX_W'(N_REQ-1)) ? '0 : w_win + IDX_W'(1);
            end else if (fetch_ready) begin
                r_fv <= 1'b0;
            end
            if (dpb_stall && |req_valid && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            if (w_cmpl_bad)
                r_err <= 1'b1;
            for (int i = 0; i < N_REQ; i++)
                r_cnt[i] <= r_cnt[i] + CNT_W'(w_inc[i]) - CNT_W'(w_hit[i] && w_nz[i]);
        end
    end
endmodule
